// File: rtl/experiment_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// experiment_cmd_sequencer
//
// Drives the experiment data mux command interface for one complete run.
// When start is accepted in IDLE, the block latches the operand set and the
// frame id. It then issues one WRITE_OP commit per operand and waits a fixed
// settle interval. Next it issues one READ_RESULT commit per result, capturing
// each returned word into the result bank. Software therefore triggers a
// whole experiment with a single start.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         single-cycle run request, honoured only in IDLE
//   frame_id      frame index for command[23:16], latched at accepted start
//   operands_in   packed operands (index 0 at LSBs), latched at accepted start
//   busy          high from accepted start until the done cycle
//   done          one-cycle pulse once every result is captured
//   results_out   captured results (index 0 at LSBs), held between runs
//   mux_commit    command strobe to the mux
//   mux_command   {index[31:24], frame[23:16], operation[15:0]}
//   mux_wdata     operand zero-extended to 32 bits, valid with mux_commit
//   mux_rdata     mux data_out, registered by the mux on the commit edge
//   state_dbg     current FSM state encoding (observation only)
//
// Handshake: the mux has no back-pressure. Every cycle in which mux_commit
// is high carries exactly one command, and the mux consumes it on that edge.
// For a read, the mux presents the answer on mux_rdata during the following
// cycle.
// -----------------------------------------------------------------------------
module experiment_cmd_sequencer #(
  parameter int          OPERAND_COUNT    = 2,
  parameter int          OPERAND_WIDTH    = 16,
  parameter int          RESULT_COUNT     = 1,
  parameter int          RESULT_WIDTH     = 32,
  parameter int          SETTLE_CYCLES    = 4,
  parameter logic [15:0] WRITE_OP_CODE    = 16'h0001,
  parameter logic [15:0] READ_RESULT_CODE = 16'h0002
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [7:0]                             frame_id,
  input  logic [OPERAND_COUNT*OPERAND_WIDTH-1:0] operands_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [RESULT_COUNT*RESULT_WIDTH-1:0]   results_out,
  output logic                                   mux_commit,
  output logic [31:0]                            mux_command,
  output logic [31:0]                            mux_wdata,
  input  logic [31:0]                            mux_rdata,
  output logic [2:0]                             state_dbg
);

  localparam int OP_W  = (OPERAND_COUNT > 1) ? $clog2(OPERAND_COUNT) : 1;
  localparam int RES_W = (RESULT_COUNT > 1)  ? $clog2(RESULT_COUNT)  : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(OPERAND_COUNT - 1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESULT_COUNT - 1);
  // When SETTLE_CYCLES is 0 the SETTLE state is never entered. Clamping the
  // terminal value keeps the constant in range for that case.
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_SETTLE = 3'd2,
    S_READ   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                                 state, state_d;
  logic [OP_W-1:0]                        op_idx, op_idx_d, op_next;
  logic [RES_W-1:0]                       res_idx, res_idx_d, res_next;
  logic [SET_W-1:0]                       set_cnt, set_cnt_d;
  logic [OPERAND_COUNT*OPERAND_WIDTH-1:0] ops_q;
  logic [7:0]                             frame_q;
  logic                                   accept;
  logic                                   busy_d, done_d, commit_d;
  logic [31:0]                            command_d, wdata_d;
  // Capture pipeline: a read commit in cycle t is answered on mux_rdata in
  // cycle t+1, so the index is carried one stage behind the issue side.
  logic                                   cap_pend;
  logic [RES_W-1:0]                       cap_idx;

  assign op_next   = op_idx + 1'b1;
  assign res_next  = res_idx + 1'b1;
  assign state_dbg = state;

  // Outputs are computed for the next cycle and registered together with the
  // state, so every command lands on the bus in the cycle its state is active.
  always_comb begin
    state_d   = state;
    op_idx_d  = op_idx;
    res_idx_d = res_idx;
    set_cnt_d = set_cnt;
    busy_d    = busy;
    done_d    = 1'b0;
    commit_d  = 1'b0;
    command_d = '0;
    wdata_d   = '0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_d   = S_WRITE;
          busy_d    = 1'b1;
          op_idx_d  = '0;
          commit_d  = 1'b1;
          command_d = {8'd0, frame_id, WRITE_OP_CODE};
          // ops_q is not yet loaded, so operand 0 comes straight from the port.
          wdata_d   = 32'(operands_in[OPERAND_WIDTH-1:0]);
        end
      end
      S_WRITE: begin
        if (op_idx == OP_LAST) begin
          if (SETTLE_CYCLES == 0) begin
            state_d   = S_READ;
            res_idx_d = '0;
            commit_d  = 1'b1;
            command_d = {8'd0, frame_q, READ_RESULT_CODE};
          end else begin
            state_d   = S_SETTLE;
            set_cnt_d = '0;
          end
        end else begin
          op_idx_d  = op_next;
          commit_d  = 1'b1;
          command_d = {8'(op_next), frame_q, WRITE_OP_CODE};
          wdata_d   = 32'(ops_q[int'(op_next)*OPERAND_WIDTH +: OPERAND_WIDTH]);
        end
      end
      S_SETTLE: begin
        if (set_cnt == SET_LAST) begin
          state_d   = S_READ;
          res_idx_d = '0;
          commit_d  = 1'b1;
          command_d = {8'd0, frame_q, READ_RESULT_CODE};
        end else begin
          set_cnt_d = set_cnt + 1'b1;
        end
      end
      S_READ: begin
        if (res_idx == RES_LAST) begin
          state_d = S_DRAIN;
        end else begin
          res_idx_d = res_next;
          commit_d  = 1'b1;
          command_d = {8'(res_next), frame_q, READ_RESULT_CODE};
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        op_idx_d  = '0;
        res_idx_d = '0;
        set_cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_idx      <= '0;
      res_idx     <= '0;
      set_cnt     <= '0;
      ops_q       <= '0;
      frame_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mux_commit  <= 1'b0;
      mux_command <= '0;
      mux_wdata   <= '0;
      cap_pend    <= 1'b0;
      cap_idx     <= '0;
      results_out <= '0;
    end else begin
      state       <= state_d;
      op_idx      <= op_idx_d;
      res_idx     <= res_idx_d;
      set_cnt     <= set_cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      mux_commit  <= commit_d;
      mux_command <= command_d;
      mux_wdata   <= wdata_d;
      if (accept) begin
        ops_q   <= operands_in;
        frame_q <= frame_id;
      end
      cap_pend <= (state == S_READ);
      cap_idx  <= res_idx;
      if (cap_pend) begin
        results_out[int'(cap_idx)*RESULT_WIDTH +: RESULT_WIDTH] <= mux_rdata[RESULT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_experiment_cmd_sequencer.sv
module tb_experiment_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cyc = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: default parameters ----------------
  logic        a_start, a_busy, a_done, a_commit;
  logic [7:0]  a_frame;
  logic [31:0] a_ops, a_res, a_cmd, a_wdata, a_rdata;
  logic [2:0]  a_state;

  experiment_cmd_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .frame_id(a_frame),
    .operands_in(a_ops), .busy(a_busy), .done(a_done), .results_out(a_res),
    .mux_commit(a_commit), .mux_command(a_cmd), .mux_wdata(a_wdata),
    .mux_rdata(a_rdata), .state_dbg(a_state)
  );

  // ---------------- DUT B: 3 operands x12, 3 results x16, no settle ----------------
  logic        b_start, b_busy, b_done, b_commit;
  logic [7:0]  b_frame;
  logic [35:0] b_ops;
  logic [47:0] b_res;
  logic [31:0] b_cmd, b_wdata, b_rdata;
  logic [2:0]  b_state;

  experiment_cmd_sequencer #(
    .OPERAND_COUNT(3), .OPERAND_WIDTH(12), .RESULT_COUNT(3),
    .RESULT_WIDTH(16), .SETTLE_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .frame_id(b_frame),
    .operands_in(b_ops), .busy(b_busy), .done(b_done), .results_out(b_res),
    .mux_commit(b_commit), .mux_command(b_cmd), .mux_wdata(b_wdata),
    .mux_rdata(b_rdata), .state_dbg(b_state)
  );

  // Mux models: a read commit loads the answer on the commit edge; every other
  // edge loads noise, so the answer is valid for exactly one cycle.
  always @(posedge clk) begin
    if (a_commit && a_cmd[15:0] == 16'h0002) a_rdata <= 32'hCAFE0001 + {24'd0, a_cmd[31:24]};
    else a_rdata <= $urandom;
    if (b_commit && b_cmd[15:0] == 16'h0002)
      b_rdata <= 32'hABCD0100 + {16'd0, b_cmd[23:16], 8'd0} + {24'd0, b_cmd[31:24]};
    else b_rdata <= $urandom;
  end

  // Scoreboards: {cycle, command, wdata} pushed at start, popped per commit.
  logic [95:0] exp_a_q[$];
  logic [95:0] exp_b_q[$];
  logic [95:0] ea, eb;

  always @(negedge clk) begin
    if (a_commit) begin
      total = total + 1;
      if (exp_a_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL a_commit_unexpected cyc=%0d cmd=%h wdata=%h required no commit", cyc, a_cmd, a_wdata);
      end else begin
        ea = exp_a_q.pop_front();
        if ({cyc, a_cmd, a_wdata} !== ea) begin
          bad = bad + 1;
          $display("FAIL a_commit got cyc=%0d cmd=%h wdata=%h required cyc=%0d cmd=%h wdata=%h",
                   cyc, a_cmd, a_wdata, ea[95:64], ea[63:32], ea[31:0]);
        end
      end
    end
    if (b_commit) begin
      total = total + 1;
      if (exp_b_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL b_commit_unexpected cyc=%0d cmd=%h wdata=%h required no commit", cyc, b_cmd, b_wdata);
      end else begin
        eb = exp_b_q.pop_front();
        if ({cyc, b_cmd, b_wdata} !== eb) begin
          bad = bad + 1;
          $display("FAIL b_commit got cyc=%0d cmd=%h wdata=%h required cyc=%0d cmd=%h wdata=%h",
                   cyc, b_cmd, b_wdata, eb[95:64], eb[63:32], eb[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Start is sampled at the edge after cycle s; write i lands in s+1+i,
  // reads follow after OPERAND_COUNT writes and SETTLE_CYCLES idle cycles.
  task automatic start_a(input logic [7:0] f, input logic [31:0] ops, output logic [31:0] s);
    @(negedge clk);
    a_start = 1'b1; a_frame = f; a_ops = ops; s = cyc;
    for (int i = 0; i < 2; i++)
      exp_a_q.push_back({32'(s + 1 + i), 8'(i), f, 16'h0001, 16'd0, ops[i*16 +: 16]});
    exp_a_q.push_back({32'(s + 7), 8'd0, f, 16'h0002, 32'd0});
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] f, input logic [35:0] ops, output logic [31:0] s);
    @(negedge clk);
    b_start = 1'b1; b_frame = f; b_ops = ops; s = cyc;
    for (int i = 0; i < 3; i++)
      exp_b_q.push_back({32'(s + 1 + i), 8'(i), f, 16'h0001, 20'd0, ops[i*12 +: 12]});
    for (int k = 0; k < 3; k++)
      exp_b_q.push_back({32'(s + 4 + k), 8'(k), f, 16'h0002, 32'd0});
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic wait_done_a(output logic [31:0] dc, output bit ok);
    ok = 1'b0; dc = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_done) begin dc = cyc; ok = 1'b1; return; end
    end
  endtask

  task automatic wait_done_b(output logic [31:0] dc, output bit ok);
    ok = 1'b0; dc = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_done) begin dc = cyc; ok = 1'b1; return; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total = total + 1;
    if ({a_busy, a_done, a_commit, a_cmd, a_wdata, a_res, a_state} !== '0) begin
      bad = bad + 1;
      $display("FAIL reset_a got busy=%b done=%b commit=%b cmd=%h wdata=%h res=%h state=%0d required all 0",
               a_busy, a_done, a_commit, a_cmd, a_wdata, a_res, a_state);
    end
    total = total + 1;
    if ({b_busy, b_done, b_commit, b_cmd, b_wdata, b_res, b_state} !== '0) begin
      bad = bad + 1;
      $display("FAIL reset_b got busy=%b done=%b commit=%b cmd=%h wdata=%h res=%h state=%0d required all 0",
               b_busy, b_done, b_commit, b_cmd, b_wdata, b_res, b_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    int          seen;
    start_a(8'h77, 32'h5555_AAAA, s);
    @(negedge clk);          // write idx 1 on the bus
    #1 rst_n = 1'b0;
    #1;
    total = total + 1;
    if ({a_busy, a_done, a_commit, a_cmd, a_wdata, a_state} !== '0) begin
      bad = bad + 1;
      $display("FAIL reset_mid_run got busy=%b done=%b commit=%b cmd=%h wdata=%h state=%0d required all 0",
               a_busy, a_done, a_commit, a_cmd, a_wdata, a_state);
    end
    total = total + 1;
    if (exp_a_q.size() != 1) begin
      bad = bad + 1;
      $display("FAIL reset_mid_run_writes got pending=%0d required 1 (only the read left)", exp_a_q.size());
    end
    exp_a_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_commit) seen++;
    end
    total = total + 1;
    if (seen != 0) begin
      bad = bad + 1;
      $display("FAIL reset_mid_run_quiet got commits=%0d required 0", seen);
    end
  endtask

  task automatic test_basic();
    logic [31:0] s, dc;
    bit          ok;
    start_a(8'h05, {16'hBEEF, 16'h1234}, s);
    total = total + 1;
    if (a_busy !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL basic_busy got %b required 1", a_busy);
    end
    wait_done_a(dc, ok);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("FAIL basic_done_timeout got no done required done");
    end
    total = total + 1;
    if (dc !== s + 9) begin
      bad = bad + 1;
      $display("FAIL basic_done_cycle got %0d required %0d", dc, s + 9);
    end
    total = total + 1;
    if ({a_busy, a_res} !== {1'b0, 32'hCAFE0001}) begin
      bad = bad + 1;
      $display("FAIL basic_result got busy=%b res=%h required busy=0 res=cafe0001", a_busy, a_res);
    end
    @(negedge clk);
    total = total + 1;
    if ({a_done, a_state} !== {1'b0, 3'd0}) begin
      bad = bad + 1;
      $display("FAIL basic_after_done got done=%b state=%0d required done=0 state=0", a_done, a_state);
    end
    total = total + 1;
    if (exp_a_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL basic_commits_missing got pending=%0d required 0", exp_a_q.size());
    end
  endtask

  task automatic test_persistence();
    repeat (20) begin
      @(negedge clk);
      total = total + 1;
      if ({a_commit, a_res} !== {1'b0, 32'hCAFE0001}) begin
        bad = bad + 1;
        $display("FAIL persist got commit=%b res=%h required commit=0 res=cafe0001", a_commit, a_res);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] s, dc, ops;
    bit          ok;
    ops = $urandom;
    start_a(8'h21, ops, s);
    @(negedge clk);          // cycle s+2
    @(negedge clk);          // cycle s+3, first settle cycle
    a_start = 1'b1; a_frame = 8'hEE; a_ops = ~ops;
    @(negedge clk);
    a_start = 1'b0;
    wait_done_a(dc, ok);
    total = total + 1;
    if (!ok || dc !== s + 9) begin
      bad = bad + 1;
      $display("FAIL busy_start_timing got ok=%0d cyc=%0d required ok=1 cyc=%0d", ok, dc, s + 9);
    end
    total = total + 1;
    if (a_res !== 32'hCAFE0001) begin
      bad = bad + 1;
      $display("FAIL busy_start_result got %h required cafe0001", a_res);
    end
    // A start presented in the DONE cycle must also be dropped.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    total = total + 1;
    if ({a_busy, a_state, 32'(exp_a_q.size())} !== {1'b0, 3'd0, 32'd0}) begin
      bad = bad + 1;
      $display("FAIL done_cycle_start got busy=%b state=%0d pending=%0d required 0/0/0",
               a_busy, a_state, exp_a_q.size());
    end
  endtask

  task automatic test_multi_zero_settle();
    logic [31:0] s, dc;
    logic [35:0] ops;
    bit          ok;
    for (int i = 0; i < 3; i++) ops[i*12 +: 12] = 12'($urandom_range(0, 4095));
    start_b(8'h00, ops, s);
    wait_done_b(dc, ok);
    total = total + 1;
    if (!ok || dc !== s + 8) begin
      bad = bad + 1;
      $display("FAIL multi_done got ok=%0d cyc=%0d required ok=1 cyc=%0d", ok, dc, s + 8);
    end
    total = total + 1;
    if (b_res !== {16'h0102, 16'h0101, 16'h0100}) begin
      bad = bad + 1;
      $display("FAIL multi_results got %h required 010201010100", b_res);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s, dc;
    logic [35:0] ops;
    logic [7:0]  f;
    bit          ok;
    for (int r = 0; r < 3; r++) begin
      f = 8'($urandom_range(1, 254));
      for (int i = 0; i < 3; i++) ops[i*12 +: 12] = 12'($urandom_range(0, 4095));
      start_b(f, ops, s);
      wait_done_b(dc, ok);
      total = total + 1;
      if (!ok || dc !== s + 8) begin
        bad = bad + 1;
        $display("FAIL b2b_done run=%0d got ok=%0d cyc=%0d required ok=1 cyc=%0d", r, ok, dc, s + 8);
      end
      total = total + 1;
      if (b_res !== {8'(f + 1), 8'h02, 8'(f + 1), 8'h01, 8'(f + 1), 8'h00}) begin
        bad = bad + 1;
        $display("FAIL b2b_results run=%0d got %h required %h", r, b_res,
                 {8'(f + 1), 8'h02, 8'(f + 1), 8'h01, 8'(f + 1), 8'h00});
      end
    end
    @(negedge clk);
    total = total + 1;
    if (exp_b_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL b_commits_missing got pending=%0d required 0", exp_b_q.size());
    end
  endtask

  initial begin
    a_start = 1'b0; a_frame = '0; a_ops = '0;
    b_start = 1'b0; b_frame = '0; b_ops = '0;
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_persistence();
    test_start_while_busy();
    test_multi_zero_settle();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
